pnctrl: RTL and testbench
=========================

# pnctrl

Parametrised N-buffer ownership controller for a packet filter core; successor to the fixed three-buffer (ping/pang/pong) controller. It arbitrates `N_BUFS` packet buffers among three agents: snooper (A), CPU (B) and forwarder (C). Buffer indices are kept in FIFO order, so packets are filtered and forwarded in arrival order. The block sits between the agents and the buffer muxes, driving per-agent and per-buffer select codes.

## Interface
- `N_BUFS`, 4: number of packet buffers; legal range 2..16.
- `IDX_W`, `$clog2(N_BUFS)`: width of a buffer index; derived, never overridden.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `A_done`  in  1  snooper finished writing its held buffer.
- `rdy_for_A`  out  1  free buffer available and snooper holds none.
- `rdy_for_A_ack`  in  1  snooper claims the head of the free queue.
- `B_acc`, `B_rej`  in  1 each  CPU verdict on its held buffer.
- `rdy_for_B`  out  1  filled buffer available and CPU holds none.
- `rdy_for_B_ack`  in  1  CPU claims the head of the CPU queue.
- `C_done`  in  1  forwarder finished reading its held buffer.
- `rdy_for_C`  out  1  accepted buffer available and forwarder holds none.
- `rdy_for_C_ack`  in  1  forwarder claims the head of the forward queue.
- `sn_sel`, `cpu_sel`, `fwd_sel`  out  IDX_W each  index of the buffer held by the agent; 0 when idle.
- `sn_vld`, `cpu_vld`, `fwd_vld`  out  1 each  agent holds a buffer.
- `buf_own`  out  2*N_BUFS  per-buffer owner code; bits [2i+1:2i] belong to buffer i.
- `free_cnt`, `cpu_cnt`, `fwd_cnt`  out  IDX_W+1 each  queue occupancies.

## Operation
- Owner codes: 00 queued (free, CPU or forward queue), 01 snooper, 10 CPU, 11 forwarder.
- Three circular index queues, each of depth `N_BUFS`: free, CPU, forward. Every buffer is at all times either in exactly one queue or held by exactly one agent.
- Reset: free queue holds 0,1,…,N_BUFS-1 (head = 0); other queues empty; all `*_vld`=0, `*_sel`=0, counts `free_cnt`=N_BUFS, others 0; all `buf_own`=00; all `rdy_for_*`=0 while `rst` is high.
- `rdy_for_X` = !rst & !X_vld & (queue_X not empty); combinational from registered state only.
- Claim: `rdy_for_X_ack` while `rdy_for_X` is high pops the head into `X_sel` and sets `X_vld`. An ack while `rdy_for_X` is low is ignored.
- Release:
  - `A_done` pushes `sn_sel` to the CPU queue.
  - `B_acc` pushes `cpu_sel` to the forward queue.
  - `B_rej` pushes `cpu_sel` to the free queue.
  - `C_done` pushes `fwd_sel` to the free queue.
  - Each release clears the agent's `vld`.
  - A release while the agent's `vld`=0 is ignored.
- `B_acc` and `B_rej` together: reject wins, and the buffer goes to the free queue.
- `B_rej` and `C_done` in the same cycle: the free queue takes two pushes, CPU buffer first, then the forwarder buffer.
- A push and a pop on the same queue in one cycle both apply; the count changes by pushes minus pops.
- No bypass: a buffer pushed in cycle t is claimable no earlier than t+1.
- Release and claim by the same agent in one cycle: the claim is ignored, because `rdy` was low.
- Queues cannot overflow by construction. The bench asserts that the sum of counts plus held buffers equals N_BUFS every cycle.
- `rst` mid-operation: all state returns to the reset state on the next edge, and held buffers are discarded.

## Timing
- Claim ack at edge t: `X_sel`/`X_vld`/`buf_own` updated after t; `rdy_for_X` low from t+1.
- Release at edge t: the buffer appears in the destination queue after t; the downstream `rdy` can rise in cycle t+1.
- Minimum buffer round trip (A claim → A done → B claim → B acc → C claim → C done) is 6 cycles with immediate acks.
- Counts are registered and exact after each edge.

## Structure
- Package `pnctrl_pkg`: owner codes `OWN_Q`, `OWN_SN`, `OWN_CPU`, `OWN_FWD`; `MAX_BUFS`=16.
- Sub-module `idx_fifo`:
  - Parameters: `DEPTH`, `W`.
  - One pop port and two ordered push ports (`push0` takes priority in order).
  - `count` output.
  - Reset init mode that fills the queue with 0..DEPTH-1.
  - Instantiated three times; only the free queue uses the second push port.

## Test plan
- Reset, N_BUFS=4 → `rdy_for_A`=0 during rst, =1 next cycle; `free_cnt`=4; `buf_own`=0.
- A ack, A_done, B ack, B_acc, C ack, C_done (one per cycle) → `sn_sel`=0 → `cpu_sel`=0 → `fwd_sel`=0; buffer 0 returns to the free tail (queue 1,2,3,0).
- A claims and fills buffers 0,1,2 in turn; CPU rejects 0 and accepts 1, 2 → forward order 1,2; free queue 3,0.
- Same cycle `B_rej` (cpu_sel=2) and `C_done` (fwd_sel=1) → free queue tail order …,2,1; `free_cnt`+2.
- `rdy_for_B_ack` with CPU queue empty, `C_done` with `fwd_vld`=0, and `B_acc`+`B_rej` together → first two ignored, reject wins.
- 2000 cycles random stimulus with N_BUFS=2,3,16 → conservation invariant holds; no index held twice; FIFO order preserved.

Source files
------------

// File: rtl/pnctrl_pkg.sv
// Shared owner codes and limits for the packet-buffer ownership controller.
package pnctrl_pkg;

    localparam int MAX_BUFS = 16;

    typedef enum logic [1:0] {
        OWN_Q   = 2'b00,
        OWN_SN  = 2'b01,
        OWN_CPU = 2'b10,
        OWN_FWD = 2'b11
    } own_t;

endpackage

// File: rtl/idx_fifo.sv
// Circular queue of buffer indices: one pop, two ordered pushes (push0 lands first).
// Latency: push visible at head from the next cycle; no overflow guard, the owner keeps occupancy bounded.
// Backpressure: none internally; the caller only pops when count is non-zero.
module idx_fifo #(
    parameter int DEPTH     = 4,
    parameter int W         = $clog2(DEPTH),
    parameter bit INIT_FILL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pop,
    input  logic         push0,
    input  logic [W-1:0] push0_dat,
    input  logic         push1,
    input  logic [W-1:0] push1_dat,
    output logic [W-1:0] head,
    output logic [W:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_ptr;
    logic [W-1:0] wr_ptr;
    logic [W-1:0] wr_slot1;
    logic [W-1:0] wr_next;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [W-1:0] inc(input logic [W-1:0] p);
        return (p == W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head     = mem[rd_ptr];
    assign wr_slot1 = push0 ? inc(wr_ptr) : wr_ptr;
    assign wr_next  = (push0 && push1) ? inc(inc(wr_ptr)) :
                      (push0 || push1) ? inc(wr_ptr) : wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_FILL ? W'(i) : '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= INIT_FILL ? (W+1)'(DEPTH) : '0;
        end else begin
            if (push0) mem[wr_ptr]   <= push0_dat;
            if (push1) mem[wr_slot1] <= push1_dat;
            if (pop)   rd_ptr        <= inc(rd_ptr);
            wr_ptr <= wr_next;
            count  <= count + (W+1)'(push0) + (W+1)'(push1) - (W+1)'(pop);
        end
    end

endmodule

// File: rtl/pnctrl.sv
// N-buffer ownership controller: free -> snooper -> CPU -> forwarder -> free, FIFO order kept.
// Latency: claims and releases take effect at the next edge; a pushed index is claimable one cycle later.
// Backpressure: rdy_for_X holds low while agent X holds a buffer or its queue is empty.
module pnctrl
    import pnctrl_pkg::*;
#(
    parameter int N_BUFS = 4,
    parameter int IDX_W  = $clog2(N_BUFS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                A_done,
    output logic                rdy_for_A,
    input  logic                rdy_for_A_ack,
    input  logic                B_acc,
    input  logic                B_rej,
    output logic                rdy_for_B,
    input  logic                rdy_for_B_ack,
    input  logic                C_done,
    output logic                rdy_for_C,
    input  logic                rdy_for_C_ack,
    output logic [IDX_W-1:0]    sn_sel,
    output logic [IDX_W-1:0]    cpu_sel,
    output logic [IDX_W-1:0]    fwd_sel,
    output logic                sn_vld,
    output logic                cpu_vld,
    output logic                fwd_vld,
    output logic [2*N_BUFS-1:0] buf_own,
    output logic [IDX_W:0]      free_cnt,
    output logic [IDX_W:0]      cpu_cnt,
    output logic [IDX_W:0]      fwd_cnt
);

    logic [IDX_W-1:0] free_head;
    logic [IDX_W-1:0] cpu_head;
    logic [IDX_W-1:0] fwd_head;
    logic             claim_a, claim_b, claim_c;
    logic             rel_a, rel_acc, rel_rej, rel_c;

    assign rdy_for_A = !rst && !sn_vld  && (free_cnt != '0);
    assign rdy_for_B = !rst && !cpu_vld && (cpu_cnt  != '0);
    assign rdy_for_C = !rst && !fwd_vld && (fwd_cnt  != '0);

    assign claim_a = rdy_for_A_ack && rdy_for_A;
    assign claim_b = rdy_for_B_ack && rdy_for_B;
    assign claim_c = rdy_for_C_ack && rdy_for_C;

    // Reject dominates accept when the CPU raises both.
    assign rel_a   = A_done && sn_vld;
    assign rel_rej = B_rej  && cpu_vld;
    assign rel_acc = B_acc  && !B_rej && cpu_vld;
    assign rel_c   = C_done && fwd_vld;

    // Free queue: CPU reject is pushed ahead of the forwarder's return.
    idx_fifo #(.DEPTH(N_BUFS), .W(IDX_W), .INIT_FILL(1'b1)) u_free_q (
        .clk(clk), .rst(rst), .pop(claim_a),
        .push0(rel_rej), .push0_dat(cpu_sel),
        .push1(rel_c),   .push1_dat(fwd_sel),
        .head(free_head), .count(free_cnt)
    );

    idx_fifo #(.DEPTH(N_BUFS), .W(IDX_W), .INIT_FILL(1'b0)) u_cpu_q (
        .clk(clk), .rst(rst), .pop(claim_b),
        .push0(rel_a),  .push0_dat(sn_sel),
        .push1(1'b0),   .push1_dat('0),
        .head(cpu_head), .count(cpu_cnt)
    );

    idx_fifo #(.DEPTH(N_BUFS), .W(IDX_W), .INIT_FILL(1'b0)) u_fwd_q (
        .clk(clk), .rst(rst), .pop(claim_c),
        .push0(rel_acc), .push0_dat(cpu_sel),
        .push1(1'b0),    .push1_dat('0),
        .head(fwd_head), .count(fwd_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sn_vld  <= 1'b0;
            sn_sel  <= '0;
            cpu_vld <= 1'b0;
            cpu_sel <= '0;
            fwd_vld <= 1'b0;
            fwd_sel <= '0;
        end else begin
            if (claim_a) begin
                sn_vld <= 1'b1;
                sn_sel <= free_head;
            end else if (rel_a) begin
                sn_vld <= 1'b0;
                sn_sel <= '0;
            end
            if (claim_b) begin
                cpu_vld <= 1'b1;
                cpu_sel <= cpu_head;
            end else if (rel_acc || rel_rej) begin
                cpu_vld <= 1'b0;
                cpu_sel <= '0;
            end
            if (claim_c) begin
                fwd_vld <= 1'b1;
                fwd_sel <= fwd_head;
            end else if (rel_c) begin
                fwd_vld <= 1'b0;
                fwd_sel <= '0;
            end
        end
    end

    // Queued buffers read as OWN_Q; held ones carry their agent's code.
    always_comb begin
        buf_own = '0;
        for (int i = 0; i < N_BUFS; i++) begin
            if (sn_vld  && sn_sel  == IDX_W'(i)) buf_own[2*i +: 2] = OWN_SN;
            if (cpu_vld && cpu_sel == IDX_W'(i)) buf_own[2*i +: 2] = OWN_CPU;
            if (fwd_vld && fwd_sel == IDX_W'(i)) buf_own[2*i +: 2] = OWN_FWD;
        end
    end

endmodule

// File: tb/tb_pnctrl.sv
// Four pnctrl instances (N_BUFS = 4, 2, 3, 16) checked every cycle against a queue-level model;
// instance 0 first runs directed scenarios pinned with literal expectations.
module tb_pnctrl;

    localparam int NI = 4;
    // Stimulus bit positions within a per-instance drive vector.
    localparam logic [6:0] AD = 7'd1, AA = 7'd2, BA = 7'd4, BR = 7'd8, BK = 7'd16, CD = 7'd32, CK = 7'd64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [NI];
    logic [6:0]  drv   [NI];
    logic        rdy_a [NI], rdy_b [NI], rdy_c [NI];
    logic        snv [NI], cpv [NI], fwv [NI];
    logic [3:0]  sns [NI], cps [NI], fws [NI];
    logic [31:0] own [NI];
    logic [4:0]  fcnt [NI], ccnt [NI], wcnt [NI];

    int fq [NI][$];
    int cq [NI][$];
    int wq [NI][$];
    int hs [NI], hc [NI], hf [NI];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic int nb(input int g);
        return (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : 16;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : 16;
        localparam int W = $clog2(N);
        logic [W-1:0]   sn_sel, cpu_sel, fwd_sel;
        logic [2*N-1:0] buf_own;
        logic [W:0]     f_c, c_c, w_c;
        logic           ra, rb, rc, sv, cv, fv;

        pnctrl #(.N_BUFS(N)) u_dut (
            .clk(clk), .rst(rst_v[g]),
            .A_done(drv[g][0]), .rdy_for_A(ra), .rdy_for_A_ack(drv[g][1]),
            .B_acc(drv[g][2]), .B_rej(drv[g][3]), .rdy_for_B(rb), .rdy_for_B_ack(drv[g][4]),
            .C_done(drv[g][5]), .rdy_for_C(rc), .rdy_for_C_ack(drv[g][6]),
            .sn_sel(sn_sel), .cpu_sel(cpu_sel), .fwd_sel(fwd_sel),
            .sn_vld(sv), .cpu_vld(cv), .fwd_vld(fv),
            .buf_own(buf_own), .free_cnt(f_c), .cpu_cnt(c_c), .fwd_cnt(w_c)
        );

        assign rdy_a[g] = ra;
        assign rdy_b[g] = rb;
        assign rdy_c[g] = rc;
        assign snv[g]   = sv;
        assign cpv[g]   = cv;
        assign fwv[g]   = fv;
        assign sns[g]   = 4'(sn_sel);
        assign cps[g]   = 4'(cpu_sel);
        assign fws[g]   = 4'(fwd_sel);
        assign own[g]   = 32'(buf_own);
        assign fcnt[g]  = 5'(f_c);
        assign ccnt[g]  = 5'(c_c);
        assign wcnt[g]  = 5'(w_c);
    end

    task automatic chk(input int g, input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %0d, want %0d", g, nm, act, exp);
        end
    endtask

    // Queue contents as hex digits, head first (only meaningful for short queues).
    function automatic int qhex(input int q[$]);
        int r = 0;
        foreach (q[i]) r = r * 16 + q[i];
        return r;
    endfunction

    task automatic model_reset(input int g);
        fq[g].delete();
        cq[g].delete();
        wq[g].delete();
        for (int i = 0; i < nb(g); i++) fq[g].push_back(i);
        hs[g] = -1;
        hc[g] = -1;
        hf[g] = -1;
    endtask

    // Next state of one instance given the inputs sampled at the coming edge.
    task automatic model_step(input int g, input logic r, input logic [6:0] v);
        bit ra, rb, rc;
        if (r) begin
            model_reset(g);
            return;
        end
        ra = (hs[g] < 0) && (fq[g].size() > 0);
        rb = (hc[g] < 0) && (cq[g].size() > 0);
        rc = (hf[g] < 0) && (wq[g].size() > 0);
        if (v[0] && hs[g] >= 0) begin cq[g].push_back(hs[g]); hs[g] = -1; end
        if (hc[g] >= 0 && v[3]) begin fq[g].push_back(hc[g]); hc[g] = -1; end
        else if (hc[g] >= 0 && v[2]) begin wq[g].push_back(hc[g]); hc[g] = -1; end
        if (v[5] && hf[g] >= 0) begin fq[g].push_back(hf[g]); hf[g] = -1; end
        if (v[1] && ra) hs[g] = fq[g].pop_front();
        if (v[4] && rb) hc[g] = cq[g].pop_front();
        if (v[6] && rc) hf[g] = wq[g].pop_front();
    endtask

    task automatic check_all();
        for (int g = 0; g < NI; g++) begin
            logic [31:0] eo;
            int held;
            eo = '0;
            if (hs[g] >= 0) eo[2*hs[g] +: 2] = 2'b01;
            if (hc[g] >= 0) eo[2*hc[g] +: 2] = 2'b10;
            if (hf[g] >= 0) eo[2*hf[g] +: 2] = 2'b11;
            chk(g, "rdy_for_A", int'(rdy_a[g]), int'(!rst_v[g] && hs[g] < 0 && fq[g].size() > 0));
            chk(g, "rdy_for_B", int'(rdy_b[g]), int'(!rst_v[g] && hc[g] < 0 && cq[g].size() > 0));
            chk(g, "rdy_for_C", int'(rdy_c[g]), int'(!rst_v[g] && hf[g] < 0 && wq[g].size() > 0));
            chk(g, "sn_vld",  int'(snv[g]), int'(hs[g] >= 0));
            chk(g, "cpu_vld", int'(cpv[g]), int'(hc[g] >= 0));
            chk(g, "fwd_vld", int'(fwv[g]), int'(hf[g] >= 0));
            chk(g, "sn_sel",  int'(sns[g]), (hs[g] < 0) ? 0 : hs[g]);
            chk(g, "cpu_sel", int'(cps[g]), (hc[g] < 0) ? 0 : hc[g]);
            chk(g, "fwd_sel", int'(fws[g]), (hf[g] < 0) ? 0 : hf[g]);
            chk(g, "buf_own", int'(own[g]), int'(eo));
            chk(g, "free_cnt", int'(fcnt[g]), fq[g].size());
            chk(g, "cpu_cnt",  int'(ccnt[g]), cq[g].size());
            chk(g, "fwd_cnt",  int'(wcnt[g]), wq[g].size());
            held = int'(snv[g]) + int'(cpv[g]) + int'(fwv[g]);
            chk(g, "conservation", int'(fcnt[g]) + int'(ccnt[g]) + int'(wcnt[g]) + held, nb(g));
        end
    endtask

    // One clock: drive at negedge, advance model, check #1 after the rising edge.
    // fr resets every instance; dir gives instance 0 the supplied vector instead of random input.
    task automatic cycle(input bit fr, input bit dir, input logic r0, input logic [6:0] v0);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            logic       r;
            logic [6:0] v;
            if (fr) begin
                r = 1'b1;
                v = '0;
            end else if (dir && g == 0) begin
                r = r0;
                v = v0;
            end else begin
                r = ($urandom_range(0, 399) == 0);
                v = 7'($urandom);
            end
            rst_v[g] = r;
            drv[g]   = v;
            model_step(g, r, v);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic d(input logic [6:0] v);
        cycle(1'b0, 1'b1, 1'b0, v);
    endtask

    task automatic d_reset();
        cycle(1'b0, 1'b1, 1'b1, '0);
    endtask

    task automatic fill3();
        for (int k = 0; k < 3; k++) begin
            d(AA);
            chk(0, "lit_fill_sn_sel", int'(sns[0]), k);
            d(AD);
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            rst_v[g] = 1'b1;
            drv[g]   = '0;
        end

        cycle(1'b1, 1'b1, 1'b1, '0);
        cycle(1'b1, 1'b1, 1'b1, '0);
        chk(0, "lit_rst_rdy_a", int'(rdy_a[0]), 0);
        chk(0, "lit_rst_free_cnt", int'(fcnt[0]), 4);
        chk(0, "lit_rst_buf_own", int'(own[0]), 0);
        d('0);
        chk(0, "lit_post_rst_rdy_a", int'(rdy_a[0]), 1);

        // Minimum round trip of buffer 0.
        d(AA); chk(0, "lit_rt_sn_sel", int'(sns[0]), 0); chk(0, "lit_rt_sn_vld", int'(snv[0]), 1);
        d(AD);
        d(BK); chk(0, "lit_rt_cpu_sel", int'(cps[0]), 0); chk(0, "lit_rt_cpu_vld", int'(cpv[0]), 1);
        d(BA);
        d(CK); chk(0, "lit_rt_fwd_sel", int'(fws[0]), 0); chk(0, "lit_rt_fwd_vld", int'(fwv[0]), 1);
        d(CD);
        chk(0, "lit_rt_free_q", qhex(fq[0]), 'h1230);
        chk(0, "lit_rt_free_cnt", int'(fcnt[0]), 4);
        d(AA); chk(0, "lit_rt_next_head", int'(sns[0]), 1);

        // Reject 0, accept 1 and 2.
        d_reset();
        fill3();
        d(BK); d(BR); d(BK); d(BA); d(BK); d(BA);
        chk(0, "lit_fwd_q", qhex(wq[0]), 'h12);
        chk(0, "lit_free_q", qhex(fq[0]), 'h30);
        chk(0, "lit_fwd_cnt", int'(wcnt[0]), 2);
        chk(0, "lit_free_cnt_2", int'(fcnt[0]), 2);
        d(CK); chk(0, "lit_fwd_first", int'(fws[0]), 1);

        // Same-cycle reject and forward-done: CPU buffer enters the free queue first.
        d_reset();
        fill3();
        d(BK); d(BR); d(BK); d(BA); d(BK); d(CK);
        chk(0, "lit_dual_pre_cnt", int'(fcnt[0]), 2);
        d(BR | CD);
        chk(0, "lit_dual_post_cnt", int'(fcnt[0]), 4);
        chk(0, "lit_dual_free_q", qhex(fq[0]), 'h3021);
        d(AA); chk(0, "lit_dual_head", int'(sns[0]), 3);

        // Ignored ack/release and accept+reject together.
        d_reset();
        d(BK | CD);
        chk(0, "lit_ign_cpu_vld", int'(cpv[0]), 0);
        chk(0, "lit_ign_free_cnt", int'(fcnt[0]), 4);
        chk(0, "lit_ign_cpu_cnt", int'(ccnt[0]), 0);
        d(AA); d(AD); d(BK);
        d(BA | BR);
        chk(0, "lit_rej_wins_fwd", int'(wcnt[0]), 0);
        chk(0, "lit_rej_wins_free", int'(fcnt[0]), 4);
        chk(0, "lit_rej_wins_q", qhex(fq[0]), 'h1230);

        repeat (2000) cycle(1'b0, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
